// File: rtl/i2c_reg_access_pkg.sv
// Shared definitions for the single-register I2C master: state and quarter-phase codes,
// the latched command record and small helpers.
package i2c_reg_access_pkg;

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StStart   = 4'd1;
  localparam logic [3:0] StTxByte  = 4'd2;
  localparam logic [3:0] StRxAck   = 4'd3;
  localparam logic [3:0] StRestart = 4'd4;
  localparam logic [3:0] StRxByte  = 4'd5;
  localparam logic [3:0] StTxNack  = 4'd6;
  localparam logic [3:0] StStop    = 4'd7;
  localparam logic [3:0] StDone    = 4'd8;

  localparam logic [1:0] Qtr0 = 2'd0;
  localparam logic [1:0] Qtr1 = 2'd1;
  localparam logic [1:0] Qtr2 = 2'd2;
  localparam logic [1:0] Qtr3 = 2'd3;

  localparam logic RwWrite = 1'b0;
  localparam logic RwRead  = 1'b1;

  typedef struct packed {
    logic       op_read;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
  } cmd_t;

  function automatic int unsigned qtr_cycles(input int unsigned clk_hz,
                                             input int unsigned scl_hz);
    return clk_hz / (4 * scl_hz);
  endfunction

  function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rw);
    return {dev, rw};
  endfunction

endpackage

// File: rtl/i2c_reg_access_qtr_tick.sv
// Quarter-bit divider. Emits a one-cycle tick at the end of each quarter and the current
// 2-bit quarter phase; the end of Q1 waits for a stretched SCL to be seen high.
module i2c_reg_access_qtr_tick
  import i2c_reg_access_pkg::*;
#(
  parameter int unsigned Qtr = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       scl_in,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int unsigned CntW = (Qtr > 1) ? $clog2(Qtr) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Qtr - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      phase_q, phase_d;
  logic            at_end;
  logic            hold;

  always_comb begin
    at_end  = (cnt_q == CntMax);
    // Slave may hold SCL low after release; finish Q1 only once the bus is high.
    hold    = (phase_q == Qtr1) && !scl_in;
    tick    = en && at_end && !hold;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en) begin
      cnt_d   = '0;
      phase_d = Qtr0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else if (!at_end) begin
      cnt_d   = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= Qtr0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/i2c_reg_access.sv
// Bit-level I2C master performing one register write or read per req/ack handshake,
// driving open-drain SCL/SDA enables and reporting a slave NACK through error.
module i2c_reg_access
  import i2c_reg_access_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned I2C_FREQ_HZ = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_write_req,
  output logic       i2c_write_req_ack,
  input  logic       i2c_read_req,
  output logic       i2c_read_req_ack,
  input  logic [7:0] i2c_slave_dev_addr,
  input  logic [7:0] i2c_slave_reg_addr,
  input  logic [7:0] i2c_write_data,
  output logic [7:0] i2c_read_data,
  output logic       error,
  output logic       busy,
  input  logic       scl_pad_i,
  output logic       scl_pad_o,
  output logic       scl_padoen_o,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o
);

  localparam int unsigned Qtr = qtr_cycles(CLK_FREQ_HZ, I2C_FREQ_HZ);

  logic [3:0] state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] read_data_q, read_data_d;
  logic       error_q, error_d;
  logic       busy_q, busy_d;
  logic       ack_prev_q, ack_prev_d;
  logic       nack_q, nack_d;
  logic       scl_oen_q, scl_oen_d;
  logic       sda_oen_q, sda_oen_d;

  logic       tick;
  logic [1:0] phase;
  logic       last_qtr;
  logic       scl_bit_rel;
  logic [7:0] tx_byte;
  logic       tx_bit;

  i2c_reg_access_qtr_tick #(
    .Qtr (Qtr)
  ) u_qtr_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q != StIdle),
    .scl_in (scl_pad_i),
    .tick   (tick),
    .phase  (phase)
  );

  always_comb begin
    unique case (byte_idx_q)
      2'd0:    tx_byte = addr_byte(cmd_q.dev_addr, RwWrite);
      2'd1:    tx_byte = cmd_q.reg_addr;
      default: tx_byte = cmd_q.op_read ? addr_byte(cmd_q.dev_addr, RwRead) : cmd_q.wr_data;
    endcase
    tx_bit = tx_byte[bit_cnt_q];
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    byte_idx_d  = byte_idx_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    read_data_d = read_data_q;
    error_d     = error_q;
    busy_d      = busy_q;
    nack_d      = nack_q;
    ack_prev_d  = (state_q == StDone);
    scl_oen_d   = 1'b1;
    sda_oen_d   = 1'b1;

    last_qtr    = tick && (phase == Qtr3);
    // Ordinary bit: SCL released during Q1 and Q2, low in Q0 and Q3.
    scl_bit_rel = (phase == Qtr1) || (phase == Qtr2);

    case (state_q)
      StIdle: begin
        if (!ack_prev_q && (i2c_write_req || i2c_read_req)) begin
          cmd_d.op_read  = !i2c_write_req;
          cmd_d.dev_addr = i2c_slave_dev_addr[7:1];
          cmd_d.reg_addr = i2c_slave_reg_addr;
          cmd_d.wr_data  = i2c_write_data;
          error_d        = 1'b0;
          busy_d         = 1'b1;
          state_d        = StStart;
        end
      end

      StStart: begin
        scl_oen_d = (phase != Qtr3);
        sda_oen_d = (phase == Qtr0) || (phase == Qtr1);
        if (last_qtr) begin
          byte_idx_d = 2'd0;
          bit_cnt_d  = 3'd7;
          state_d    = StTxByte;
        end
      end

      StTxByte: begin
        scl_oen_d = scl_bit_rel;
        sda_oen_d = tx_bit;
        if (last_qtr) begin
          if (bit_cnt_q == 3'd0) begin
            state_d = StRxAck;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
      end

      StRxAck: begin
        scl_oen_d = scl_bit_rel;
        if (tick && (phase == Qtr2)) begin
          nack_d = sda_pad_i;
        end
        if (last_qtr) begin
          bit_cnt_d = 3'd7;
          if (nack_q) begin
            error_d = 1'b1;
            state_d = StStop;
          end else if (byte_idx_q == 2'd0) begin
            byte_idx_d = 2'd1;
            state_d    = StTxByte;
          end else if (byte_idx_q == 2'd1) begin
            byte_idx_d = 2'd2;
            state_d    = cmd_q.op_read ? StRestart : StTxByte;
          end else begin
            state_d    = cmd_q.op_read ? StRxByte : StStop;
          end
        end
      end

      StRestart: begin
        // SCL comes up with SDA high, then SDA falls while SCL is high.
        scl_oen_d = scl_bit_rel;
        sda_oen_d = (phase == Qtr0) || (phase == Qtr1);
        if (last_qtr) begin
          bit_cnt_d = 3'd7;
          state_d   = StTxByte;
        end
      end

      StRxByte: begin
        scl_oen_d = scl_bit_rel;
        if (tick && (phase == Qtr2)) begin
          rx_shift_d = {rx_shift_q[6:0], sda_pad_i};
        end
        if (last_qtr) begin
          if (bit_cnt_q == 3'd0) begin
            read_data_d = rx_shift_q;
            state_d     = StTxNack;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
      end

      StTxNack: begin
        scl_oen_d = scl_bit_rel;
        if (last_qtr) begin
          state_d = StStop;
        end
      end

      StStop: begin
        scl_oen_d = (phase != Qtr0);
        sda_oen_d = (phase == Qtr2) || (phase == Qtr3);
        if (last_qtr) begin
          state_d = StDone;
        end
      end

      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      byte_idx_q  <= 2'd0;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= 8'h00;
      read_data_q <= 8'h00;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
      ack_prev_q  <= 1'b0;
      nack_q      <= 1'b0;
      scl_oen_q   <= 1'b1;
      sda_oen_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      byte_idx_q  <= byte_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      read_data_q <= read_data_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
      ack_prev_q  <= ack_prev_d;
      nack_q      <= nack_d;
      scl_oen_q   <= scl_oen_d;
      sda_oen_q   <= sda_oen_d;
    end
  end

  assign i2c_write_req_ack = (state_q == StDone) && !cmd_q.op_read;
  assign i2c_read_req_ack  = (state_q == StDone) && cmd_q.op_read;
  assign i2c_read_data     = read_data_q;
  assign error             = error_q;
  assign busy              = busy_q;
  assign scl_pad_o         = 1'b0;
  assign sda_pad_o         = 1'b0;
  assign scl_padoen_o      = scl_oen_q;
  assign sda_padoen_o      = sda_oen_q;

endmodule

// File: tb/tb_i2c_reg_access.sv
// Directed bench for i2c_reg_access with an open-drain slave model on the bus.
module tb_i2c_reg_access;

  // Scaled clock keeps bit times short: QTR = 10 MHz / (4 * 100 kHz) = 25.
  localparam int unsigned Qtr = 25;
  localparam int Budget = 20000;

  logic clk = 1'b0;
  logic rst;
  logic wr_req, rd_req;
  logic [7:0] dev, reg_a, wdata;
  logic write_ack, read_ack, error, busy;
  logic [7:0] read_data;
  logic scl_pad_o, sda_pad_o, scl_padoen_o, sda_padoen_o;
  logic bfm_scl = 1'b1;
  logic bfm_sda = 1'b1;
  wire  scl_bus = scl_padoen_o & bfm_scl;
  wire  sda_bus = sda_padoen_o & bfm_sda;

  always #5 clk = ~clk;

  i2c_reg_access #(
    .CLK_FREQ_HZ (10_000_000),
    .I2C_FREQ_HZ (100_000)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i2c_write_req      (wr_req),
    .i2c_write_req_ack  (write_ack),
    .i2c_read_req       (rd_req),
    .i2c_read_req_ack   (read_ack),
    .i2c_slave_dev_addr (dev),
    .i2c_slave_reg_addr (reg_a),
    .i2c_write_data     (wdata),
    .i2c_read_data      (read_data),
    .error              (error),
    .busy               (busy),
    .scl_pad_i          (scl_bus),
    .scl_pad_o          (scl_pad_o),
    .scl_padoen_o       (scl_padoen_o),
    .sda_pad_i          (sda_bus),
    .sda_pad_o          (sda_pad_o),
    .sda_padoen_o       (sda_padoen_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave model configuration (written by the stimulus only).
  bit         nack_addr = 1'b0;
  bit         stretch_en = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  // Slave model state (written by the bus process only).
  logic [7:0] log_q[$];
  int         starts = 0;
  int         stops = 0;
  int         bitn = 0;
  int         frame_no = 0;
  logic [7:0] shreg = 8'h00;
  bit         slave_tx = 1'b0;
  bit         pending_tx = 1'b0;
  logic       mst_ack = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  event       stretch_ev;

  always @(scl_bus or sda_bus) begin
    if (scl_bus === 1'b1 && prev_scl === 1'b1 && sda_bus !== prev_sda) begin
      if (sda_bus === 1'b0) begin
        starts++;
        bitn = 0; frame_no = 0; slave_tx = 0; pending_tx = 0; bfm_sda = 1'b1;
      end else if (sda_bus === 1'b1) begin
        stops++;
        bitn = 0; slave_tx = 0; pending_tx = 0;
      end
    end else if (scl_bus === 1'b1 && prev_scl === 1'b0) begin
      if (bitn < 8 && !slave_tx) shreg = {shreg[6:0], sda_bus};
      if (bitn == 8 && slave_tx) mst_ack = sda_bus;
      bitn++;
    end else if (scl_bus === 1'b0 && prev_scl === 1'b1) begin
      if (bitn == 8 && !slave_tx) begin
        log_q.push_back(shreg);
        if (!(nack_addr && frame_no == 0)) bfm_sda = 1'b0;
        if (frame_no == 0 && shreg[0]) pending_tx = 1'b1;
      end else if (bitn == 8 && slave_tx) begin
        bfm_sda = 1'b1;
      end else if (bitn == 9) begin
        bfm_sda = 1'b1;
        bitn = 0;
        frame_no++;
        if (pending_tx) begin
          slave_tx = 1'b1; pending_tx = 1'b0; bfm_sda = rd_byte[7];
        end else begin
          slave_tx = 1'b0;
        end
      end else if (slave_tx && bitn >= 1 && bitn <= 7) begin
        bfm_sda = rd_byte[7-bitn];
      end
      if (stretch_en && frame_no == 1 && bitn == 4 && !slave_tx) -> stretch_ev;
    end
    prev_scl = scl_bus;
    prev_sda = sda_bus;
  end

  always begin
    @(stretch_ev);
    bfm_scl = 1'b0;
    repeat (1000) @(negedge clk);
    bfm_scl = 1'b1;
  end

  int wr_acks = 0;
  int rd_acks = 0;
  always @(negedge clk) begin
    if (write_ack === 1'b1) wr_acks++;
    if (read_ack === 1'b1) rd_acks++;
  end

  // Issues one command, holds req until its ack; len = ack cycle minus first busy cycle.
  task automatic run_txn(input bit rd, input logic [7:0] d, input logic [7:0] r,
                         input logic [7:0] w, output int len, output bit acked);
    int cyc;
    int bcyc;
    bcyc = -1;
    cyc = 0;
    acked = 1'b0;
    @(negedge clk);
    dev = d; reg_a = r; wdata = w;
    if (rd) rd_req = 1'b1; else wr_req = 1'b1;
    while (!acked && cyc < Budget) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && bcyc < 0) bcyc = cyc;
      if ((rd ? read_ack : write_ack) === 1'b1) acked = 1'b1;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    len = cyc - bcyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int len, b, bwa, bra, bst, bsp, cyc;
    bit acked;
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; dev = 8'h00; reg_a = 8'h00; wdata = 8'h00;
    repeat (4) @(negedge clk);
    check("rst_write_ack", write_ack, 1'b0);
    check("rst_read_ack", read_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_read_data", read_data, 8'h00);
    check("rst_scl_oen", scl_padoen_o, 1'b1);
    check("rst_sda_oen", sda_padoen_o, 1'b1);
    check("rst_pad_o", {scl_pad_o, sda_pad_o}, 2'b00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 1: plain write, all ACKed.
    b = log_q.size(); bwa = wr_acks; bst = starts; bsp = stops;
    run_txn(1'b0, 8'h72, 8'h08, 8'h35, len, acked);
    check("wr_acked", acked, 1'b1);
    check("wr_len", len, 29 * 4 * Qtr);
    check("wr_error", error, 1'b0);
    check("wr_nbytes", log_q.size() - b, 3);
    check("wr_byte0", log_q[b], 8'h72);
    check("wr_byte1", log_q[b+1], 8'h08);
    check("wr_byte2", log_q[b+2], 8'h35);
    check("wr_starts", starts - bst, 1);
    check("wr_stops", stops - bsp, 1);
    repeat (5) @(negedge clk);
    check("wr_ack_once", wr_acks - bwa, 1);
    check("wr_busy_after", busy, 1'b0);

    // 2: read with repeated start; slave returns A5.
    rd_byte = 8'hA5;
    b = log_q.size(); bra = rd_acks; bst = starts; bsp = stops;
    run_txn(1'b1, 8'h60, 8'h05, 8'h00, len, acked);
    check("rd_acked", acked, 1'b1);
    check("rd_data", read_data, 8'hA5);
    check("rd_error", error, 1'b0);
    check("rd_len", len, 39 * 4 * Qtr);
    check("rd_nbytes", log_q.size() - b, 3);
    check("rd_byte0", log_q[b], 8'h60);
    check("rd_byte1", log_q[b+1], 8'h05);
    check("rd_byte2", log_q[b+2], 8'h61);
    check("rd_starts", starts - bst, 2);
    check("rd_stops", stops - bsp, 1);
    check("rd_master_nack", mst_ack, 1'b1);
    repeat (5) @(negedge clk);
    check("rd_ack_once", rd_acks - bra, 1);

    // 3: address NACK aborts to STOP.
    nack_addr = 1'b1;
    b = log_q.size(); bsp = stops;
    run_txn(1'b0, 8'h7A, 8'h11, 8'h22, len, acked);
    check("nack_acked", acked, 1'b1);
    check("nack_error", error, 1'b1);
    check("nack_len", len, 11 * 4 * Qtr);
    check("nack_nbytes", log_q.size() - b, 1);
    check("nack_byte0", log_q[b], 8'h7A);
    check("nack_stops", stops - bsp, 1);
    check("nack_rd_data_kept", read_data, 8'hA5);
    nack_addr = 1'b0;
    repeat (5) @(negedge clk);

    // 4: slave holds SCL low 1000 clocks from the fall before bit 4 of the reg byte.
    stretch_en = 1'b1;
    b = log_q.size();
    run_txn(1'b0, 8'h3C, 8'h5A, 8'hC3, len, acked);
    stretch_en = 1'b0;
    check("str_acked", acked, 1'b1);
    check("str_len", len, 29 * 4 * Qtr + 1001 - 3 * Qtr);
    check("str_error", error, 1'b0);
    check("str_byte0", log_q[b], 8'h3C);
    check("str_byte1", log_q[b+1], 8'h5A);
    check("str_byte2", log_q[b+2], 8'hC3);
    repeat (5) @(negedge clk);

    // 5: reset in the middle of the reg byte.
    bwa = wr_acks;
    dev = 8'h72; reg_a = 8'h08; wdata = 8'h35; wr_req = 1'b1;
    repeat (14 * 4 * Qtr) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    wr_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_scl_oen", scl_padoen_o, 1'b1);
    check("mid_sda_oen", sda_padoen_o, 1'b1);
    check("mid_busy_clr", busy, 1'b0);
    repeat (200) @(negedge clk);
    check("mid_no_ack", wr_acks - bwa, 0);
    b = log_q.size();
    run_txn(1'b0, 8'h50, 8'h01, 8'h02, len, acked);
    check("post_acked", acked, 1'b1);
    check("post_error", error, 1'b0);
    check("post_byte1", log_q[b+1], 8'h01);
    check("post_byte2", log_q[b+2], 8'h02);
    repeat (5) @(negedge clk);

    // 6: simultaneous requests; write is served first.
    rd_byte = 8'h3C;
    b = log_q.size(); bwa = wr_acks; bra = rd_acks;
    @(negedge clk);
    dev = 8'h72; reg_a = 8'h08; wdata = 8'h35; wr_req = 1'b1; rd_req = 1'b1;
    acked = 1'b0; cyc = 0;
    while (!acked && cyc < Budget) begin
      @(negedge clk); cyc++;
      if (write_ack === 1'b1) acked = 1'b1;
    end
    wr_req = 1'b0;
    check("both_wr_ack", acked, 1'b1);
    check("both_rd_not_yet", rd_acks - bra, 0);
    acked = 1'b0; cyc = 0;
    while (!acked && cyc < Budget) begin
      @(negedge clk); cyc++;
      if (read_ack === 1'b1) acked = 1'b1;
    end
    rd_req = 1'b0;
    check("both_rd_ack", acked, 1'b1);
    check("both_rd_data", read_data, 8'h3C);
    check("both_nbytes", log_q.size() - b, 6);
    check("both_wr_byte2", log_q[b+2], 8'h35);
    check("both_rd_byte2", log_q[b+5], 8'h73);
    repeat (5) @(negedge clk);
    check("both_ack_counts", {16'(wr_acks - bwa), 16'(rd_acks - bra)}, {16'd1, 16'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
